// File: rtl/blackjack_table.sv
// blackjack_table: one-table blackjack round controller.
// Cards are pulled from an external source over a valid/ready handshake and
// both hands are scored with soft-ace accounting. Optional build macro
// BJ_DEALER_H17_EN makes the dealer also draw on a soft total equal to
// DEALER_STAND; without it the dealer stands on any total >= DEALER_STAND.
module blackjack_table #(
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  parameter int SCORE_W      = 6,
  parameter int MAX_CARDS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               stay,
  input  logic               card_valid,
  input  logic [3:0]         card_val,
  output logic               card_ready,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] dealer_score,
  output logic               dealer_visible,
  output logic               win,
  output logic               lose,
  output logic               draw,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_CARDS + 1);
  localparam logic [SCORE_W:0]   TGT_X = (SCORE_W+1)'(TARGET);
  localparam logic [SCORE_W-1:0] TGT   = SCORE_W'(TARGET);
  localparam logic [SCORE_W-1:0] STAND = SCORE_W'(DEALER_STAND);
  localparam logic [CNT_W-1:0]   MAXC  = CNT_W'(MAX_CARDS);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL, S_CHECK, S_PLAYER, S_P_DRAW,
    S_DEALER, S_D_DRAW, S_RESOLVE, S_DONE
  } state_t;

  // Face cards and the spare codes 14/15 all score as ten.
  function automatic logic [3:0] clamp_card(input logic [3:0] v);
    return (v > 4'd10) ? 4'd10 : v;
  endfunction

  // Hard total saturates instead of wrapping so a long hand can never look small.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // An ace may count eleven when that keeps the hand at or below the target.
  function automatic logic soft_of(input logic [SCORE_W-1:0] hard, input logic has_ace);
    return has_ace && (({1'b0, hard} + (SCORE_W+1)'(10)) <= TGT_X);
  endfunction

  function automatic logic [SCORE_W-1:0] best_of(input logic [SCORE_W-1:0] hard,
                                                 input logic has_ace);
    return soft_of(hard, has_ace) ? hard + SCORE_W'(10) : hard;
  endfunction

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;
  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic [CNT_W-1:0]   p_aces_q, p_aces_d, d_aces_q, d_aces_d;
  logic [CNT_W-1:0]   p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
  logic [3:0]         up_q, up_d;
  logic [1:0]         deal_idx_q, deal_idx_d;
  logic               vis_q, vis_d, win_q, win_d, lose_q, lose_d, draw_q, draw_d;
  logic               rdy_q, rdy_d;

  logic               real_card, is_ace, d_wants;
  logic [3:0]         cv;
  logic [SCORE_W-1:0] p_sum, d_sum, p_best, d_best, up_best;

  // Reset asserts asynchronously and releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Void cards complete the handshake but never touch a hand.
  assign real_card = card_valid && rdy_q && (card_val != 4'd0);
  assign cv        = clamp_card(card_val);
  assign is_ace    = (card_val == 4'd1);
  assign p_sum     = sat_add(p_hard_q, cv);
  assign d_sum     = sat_add(d_hard_q, cv);
  assign p_best    = best_of(p_hard_q, p_aces_q != '0);
  assign d_best    = best_of(d_hard_q, d_aces_q != '0);
  assign up_best   = best_of(SCORE_W'(up_q), up_q == 4'd1);

`ifdef BJ_DEALER_H17_EN
  assign d_wants = (d_best < STAND) || ((d_best == STAND) && soft_of(d_hard_q, d_aces_q != '0));
`else
  assign d_wants = (d_best < STAND);
`endif

  // Round sequencing, hand updates and outcome decisions.
  always_comb begin
    state_d    = state_q;
    p_hard_d   = p_hard_q;
    p_aces_d   = p_aces_q;
    p_cnt_d    = p_cnt_q;
    d_hard_d   = d_hard_q;
    d_aces_d   = d_aces_q;
    d_cnt_d    = d_cnt_q;
    up_d       = up_q;
    deal_idx_d = deal_idx_q;
    vis_d      = vis_q;
    win_d      = win_q;
    lose_d     = lose_q;
    draw_d     = draw_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          p_hard_d   = '0;
          p_aces_d   = '0;
          p_cnt_d    = '0;
          d_hard_d   = '0;
          d_aces_d   = '0;
          d_cnt_d    = '0;
          up_d       = '0;
          deal_idx_d = '0;
          vis_d      = 1'b0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          draw_d     = 1'b0;
          state_d    = S_DEAL;
        end
      end
      S_DEAL: begin
        if (real_card) begin
          deal_idx_d = deal_idx_q + 2'd1;
          if (!deal_idx_q[0]) begin
            p_hard_d = p_sum;
            p_aces_d = p_aces_q + CNT_W'(is_ace);
            p_cnt_d  = p_cnt_q + CNT_W'(1);
          end else begin
            d_hard_d = d_sum;
            d_aces_d = d_aces_q + CNT_W'(is_ace);
            d_cnt_d  = d_cnt_q + CNT_W'(1);
            if (deal_idx_q == 2'd1) up_d = cv;
            else                    state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if ((p_best == TGT) || (d_best == TGT)) begin
          win_d   = (p_best == TGT) && (d_best != TGT);
          lose_d  = (p_best != TGT) && (d_best == TGT);
          draw_d  = (p_best == TGT) && (d_best == TGT);
          vis_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_PLAYER;
        end
      end
      S_PLAYER: begin
        if (stay || (p_cnt_q >= MAXC)) begin
          vis_d   = 1'b1;
          state_d = S_DEALER;
        end else if (hit) begin
          state_d = S_P_DRAW;
        end
      end
      S_P_DRAW: begin
        if (real_card) begin
          p_hard_d = p_sum;
          p_aces_d = p_aces_q + CNT_W'(is_ace);
          p_cnt_d  = p_cnt_q + CNT_W'(1);
          if (p_sum > TGT) begin
            lose_d  = 1'b1;
            vis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_PLAYER;
          end
        end
      end
      S_DEALER: begin
        state_d = (d_wants && (d_cnt_q < MAXC)) ? S_D_DRAW : S_RESOLVE;
      end
      S_D_DRAW: begin
        if (real_card) begin
          d_hard_d = d_sum;
          d_aces_d = d_aces_q + CNT_W'(is_ace);
          d_cnt_d  = d_cnt_q + CNT_W'(1);
          state_d  = S_DEALER;
        end
      end
      S_RESOLVE: begin
        if ((d_best > TGT) || (p_best > d_best)) win_d  = 1'b1;
        else if (p_best < d_best)                lose_d = 1'b1;
        else                                     draw_d = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_DEAL) || (state_d == S_P_DRAW) || (state_d == S_D_DRAW);
  end

  // State, hands, registered ready and outcome flags.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_IDLE;
      p_hard_q   <= '0;
      p_aces_q   <= '0;
      p_cnt_q    <= '0;
      d_hard_q   <= '0;
      d_aces_q   <= '0;
      d_cnt_q    <= '0;
      up_q       <= '0;
      deal_idx_q <= '0;
      vis_q      <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      draw_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_hard_q   <= p_hard_d;
      p_aces_q   <= p_aces_d;
      p_cnt_q    <= p_cnt_d;
      d_hard_q   <= d_hard_d;
      d_aces_q   <= d_aces_d;
      d_cnt_q    <= d_cnt_d;
      up_q       <= up_d;
      deal_idx_q <= deal_idx_d;
      vis_q      <= vis_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      draw_q     <= draw_d;
      rdy_q      <= rdy_d;
    end
  end

  assign card_ready     = rdy_q;
  assign player_score   = p_best;
  assign dealer_score   = vis_q ? d_best : up_best;
  assign dealer_visible = vis_q;
  assign win            = win_q;
  assign lose           = lose_q;
  assign draw           = draw_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_blackjack_table.sv
// Directed bench for blackjack_table with a scoreboard of expected outputs.
module tb_blackjack_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, hit = 1'b0, stay = 1'b0, card_valid = 1'b0;
  logic [3:0] card_val = 4'd0;
  logic       card_ready, dealer_visible, win, lose, draw, busy;
  logic [5:0] player_score, dealer_score;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int base = 0;

  always #5 clk = ~clk;

  blackjack_table dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .stay(stay),
    .card_valid(card_valid), .card_val(card_val), .card_ready(card_ready),
    .player_score(player_score), .dealer_score(dealer_score),
    .dealer_visible(dealer_visible), .win(win), .lose(lose), .draw(draw),
    .busy(busy)
  );

  always @(posedge clk) if (card_valid && card_ready) xfers <= xfers + 1;

  typedef enum {O_PS, O_DS, O_VIS, O_WIN, O_LOSE, O_DRAW, O_RDY, O_BUSY, O_XF} obs_e;
  typedef struct {
    string tag;
    obs_e  id;
    int    val;
  } exp_t;
  exp_t sb[$];

  function automatic int observe(obs_e id);
    case (id)
      O_PS:    return int'(player_score);
      O_DS:    return int'(dealer_score);
      O_VIS:   return int'(dealer_visible);
      O_WIN:   return int'(win);
      O_LOSE:  return int'(lose);
      O_DRAW:  return int'(draw);
      O_RDY:   return int'(card_ready);
      O_BUSY:  return int'(busy);
      default: return xfers - base;
    endcase
  endfunction

  task automatic expect_val(input string tag, input obs_e id, input int v);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.id);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_card(input logic [3:0] v);
    logic got;
    got = 1'b0;
    card_valid = 1'b1;
    card_val   = v;
    for (int i = 0; i < 40 && !got; i++) begin
      if (card_ready) got = 1'b1;
      cyc();
    end
    card_valid = 1'b0;
    card_val   = 4'd0;
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL card_timeout observed %0d expected %0d", 0, 1);
    end
  endtask

  task automatic start_round();
    base  = xfers;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  task automatic pulse_stay();
    stay = 1'b1;
    cyc();
    stay = 1'b0;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy) done = 1'b1;
      else       cyc();
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL done_timeout observed %0d expected %0d", 0, 1);
    end
  endtask

  // Offer a card while the round is over; nothing should be taken.
  task automatic probe_idle();
    card_valid = 1'b1;
    card_val   = 4'd5;
    repeat (3) cyc();
    card_valid = 1'b0;
    card_val   = 4'd0;
  endtask

  task automatic expect_all_zero(input string pfx);
    expect_val({pfx, "_ps"},   O_PS,   0);
    expect_val({pfx, "_ds"},   O_DS,   0);
    expect_val({pfx, "_vis"},  O_VIS,  0);
    expect_val({pfx, "_win"},  O_WIN,  0);
    expect_val({pfx, "_lose"}, O_LOSE, 0);
    expect_val({pfx, "_draw"}, O_DRAW, 0);
    expect_val({pfx, "_rdy"},  O_RDY,  0);
    expect_val({pfx, "_busy"}, O_BUSY, 0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) cyc();
    expect_all_zero("reset");
    drain();
    rst = 1'b1;
    repeat (4) cyc();

    // Natural for the player
    start_round();
    send_card(4'd10); send_card(4'd9); send_card(4'd1); send_card(4'd7);
    wait_done();
    probe_idle();
    expect_val("nat_ps",   O_PS,   21);
    expect_val("nat_ds",   O_DS,   16);
    expect_val("nat_win",  O_WIN,  1);
    expect_val("nat_lose", O_LOSE, 0);
    expect_val("nat_vis",  O_VIS,  1);
    expect_val("nat_rdy",  O_RDY,  0);
    expect_val("nat_xf",   O_XF,   4);
    drain();

    // Player bust
    start_round();
    send_card(4'd10); send_card(4'd10); send_card(4'd6); send_card(4'd7);
    cyc();
    expect_val("bust_pre_ps",   O_PS,   16);
    expect_val("bust_pre_up",   O_DS,   10);
    expect_val("bust_pre_vis",  O_VIS,  0);
    expect_val("bust_pre_busy", O_BUSY, 1);
    drain();
    pulse_hit();
    send_card(4'd9);
    wait_done();
    probe_idle();
    expect_val("bust_ps",   O_PS,   25);
    expect_val("bust_lose", O_LOSE, 1);
    expect_val("bust_win",  O_WIN,  0);
    expect_val("bust_ds",   O_DS,   17);
    expect_val("bust_vis",  O_VIS,  1);
    expect_val("bust_xf",   O_XF,   5);
    drain();

    // Soft ace turning hard, dealer draws to 21
    start_round();
    send_card(4'd1); send_card(4'd10); send_card(4'd5); send_card(4'd6);
    cyc();
    expect_val("soft_ps", O_PS, 16);
    drain();
    pulse_hit();
    send_card(4'd10);
    cyc();
    expect_val("hard_ps",   O_PS,   16);
    expect_val("hard_busy", O_BUSY, 1);
    drain();
    pulse_stay();
    send_card(4'd5);
    wait_done();
    expect_val("soft_ds",   O_DS,   21);
    expect_val("soft_lose", O_LOSE, 1);
    expect_val("soft_draw", O_DRAW, 0);
    expect_val("soft_xf",   O_XF,   6);
    drain();

    // Dealer soft 17
    start_round();
    send_card(4'd10); send_card(4'd1); send_card(4'd8); send_card(4'd6);
    cyc();
    pulse_stay();
`ifdef BJ_DEALER_H17_EN
    send_card(4'd10);
    expect_val("h17_xf", O_XF, 5);
`else
    expect_val("h17_xf", O_XF, 4);
`endif
    wait_done();
    expect_val("h17_ps",  O_PS,  18);
    expect_val("h17_ds",  O_DS,  17);
    expect_val("h17_win", O_WIN, 1);
    drain();

    // Card coding, void card, hit+stay together
    start_round();
    send_card(4'd13);
    expect_val("k_ps", O_PS, 10);
    expect_val("k_xf", O_XF, 1);
    drain();
    send_card(4'd0);
    expect_val("void_ps",  O_PS,  10);
    expect_val("void_ds",  O_DS,  0);
    expect_val("void_xf",  O_XF,  2);
    expect_val("void_rdy", O_RDY, 1);
    drain();
    send_card(4'd5); send_card(4'd9); send_card(4'd10);
    cyc();
    expect_val("edge_ps", O_PS, 19);
    drain();
    hit  = 1'b1;
    stay = 1'b1;
    cyc();
    hit  = 1'b0;
    stay = 1'b0;
    send_card(4'd2);
    wait_done();
    expect_val("hs_ps",  O_PS,  19);
    expect_val("hs_ds",  O_DS,  17);
    expect_val("hs_win", O_WIN, 1);
    expect_val("hs_xf",  O_XF,  6);
    drain();

    // Reset while the player is drawing
    start_round();
    send_card(4'd10); send_card(4'd10); send_card(4'd6); send_card(4'd7);
    cyc();
    pulse_hit();
    expect_val("pdraw_rdy", O_RDY, 1);
    drain();
    #2 rst = 1'b0;
    #1;
    expect_all_zero("midrst");
    drain();
    repeat (2) cyc();
    rst = 1'b1;
    repeat (6) cyc();
    expect_all_zero("postrst");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
